dcache_control: RTL and testbench
=================================

Name: dcache_control

Overview:
- Control FSM for the set-associative data cache.
- Sequences the tag, valid, dirty, LRU and data register arrays: hit service, dirty-victim writeback and line fill from physical memory.
- Sits between the CPU data port and the pmem line interface; the datapath computes hit/victim status and this block issues all array loads and mux selects.
- Keeps saturating hit/miss/writeback performance counters.

Parameters:
- num_ways, 2, associativity; way_w = $clog2(num_ways), minimum 1.
- cnt_width, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit  in  1  some valid way tag-matches the current address
- hit_way  in  way_w  matching way, valid when hit=1
- lru_way  in  way_w  current victim candidate for the indexed set
- victim_dirty  in  1  valid&dirty of the way selected by way_sel
- pmem_read  out  1  line-fill request
- pmem_write  out  1  line-writeback request
- pmem_resp  in  1  pmem completion pulse
- way_sel  out  way_w  way addressed by all array loads/reads this cycle
- load_data  out  1  write data array (way_sel)
- data_src  out  1  0 = CPU write-merge, 1 = pmem line
- load_tag  out  1  write tag array (way_sel)
- load_valid  out  1  set valid (way_sel)
- load_dirty  out  1  write dirty array (way_sel)
- dirty_in  out  1  value written to dirty array
- load_lru  out  1  mark way_sel MRU
- pmem_addr_sel  out  1  0 = CPU address, 1 = {victim tag, index}
- hit_count, miss_count, wb_count  out  cnt_width each  performance counters

Behaviour:
- States: IDLE, WRITEBACK, FILL. Reset (asynchronous, immediate): state = IDLE, victim register = 0, all counters = 0.
- All strobe outputs default to 0; selects default to 0 / hit_way.
- Combinational outputs are valid the same cycle.
- Request: req = mem_read | mem_write. If both are asserted, the request is handled as a write.
- IDLE, no req: nothing asserted.
- IDLE, req & hit:
  - mem_resp = 1, way_sel = hit_way, load_lru = 1.
  - Write: also load_data = 1, data_src = 0, load_dirty = 1, dirty_in = 1.
  - hit_count += 1. Stay in IDLE. Zero-latency hit; the arrays' write-through bypass makes back-to-back requests coherent.
- IDLE, req & !hit:
  - Latch victim <= lru_way; way_sel = lru_way for victim_dirty evaluation; miss_count += 1.
  - If victim_dirty: go to WRITEBACK, else go to FILL.
  - mem_resp stays 0.
- WRITEBACK:
  - way_sel = victim, pmem_write = 1, pmem_addr_sel = 1, held until pmem_resp.
  - On pmem_resp: wb_count += 1, go to FILL.
- FILL:
  - way_sel = victim, pmem_read = 1, pmem_addr_sel = 0.
  - On pmem_resp: load_data = 1, data_src = 1, load_tag = 1, load_valid = 1, load_dirty = 1, dirty_in = 0; go to IDLE.
  - Back in IDLE the request re-evaluates as a hit, so miss latency = pmem cycles + 1.
- The victim register is stable through a miss; LRU changes in the meantime do not move the victim.
- pmem_resp in IDLE is ignored. A request deasserted mid-miss is illegal; the FSM still completes the fill and returns to IDLE.
- pmem_read and pmem_write are never asserted together.
- Reset mid-miss drops pmem strobes immediately; no array load is issued.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset during FILL with pmem_read = 1 → pmem_read falls without a clock edge; state IDLE; counters read 0.
- Read, hit = 1, hit_way = 1 → same-cycle mem_resp, way_sel = 1, load_lru = 1, no pmem activity; hit_count = 1.
- Write miss, victim clean, lru_way = 0, pmem_resp after 4 cycles → pmem_read for 4 cycles, then a fill load with dirty_in = 0. Next cycle (hit = 1) write-merge with dirty_in = 1 and mem_resp. miss_count = 1, wb_count = 0.
- Read miss, victim dirty, lru_way = 1; lru_way toggles to 0 during WRITEBACK → pmem_write with pmem_addr_sel = 1 until pmem_resp, then pmem_read. way_sel stays 1 throughout; wb_count = 1.
- mem_read and mem_write both high on a hit → treated as write: load_data = 1, dirty_in = 1.
- Force hit_count to all-ones, then issue another hit → count stays all-ones.

Source files
------------

// File: rtl/dcache_control.sv
// Purpose: control FSM for the set-associative data cache (hit service, dirty writeback, line fill) with perf counters.
// Latency: hits complete in the request cycle; misses take pmem cycles + 1 (clean) or two pmem phases + 1 (dirty).
// Backpressure: CPU request is held until mem_resp; each pmem strobe is held until pmem_resp.
module dcache_control #(
    parameter int num_ways  = 2,
    parameter int cnt_width = 32,
    localparam int way_w    = (num_ways > 1) ? $clog2(num_ways) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic [way_w-1:0]     hit_way,
    input  logic [way_w-1:0]     lru_way,
    input  logic                 victim_dirty,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [way_w-1:0]     way_sel,
    output logic                 load_data,
    output logic                 data_src,
    output logic                 load_tag,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 dirty_in,
    output logic                 load_lru,
    output logic                 pmem_addr_sel,
    output logic [cnt_width-1:0] hit_count,
    output logic [cnt_width-1:0] miss_count,
    output logic [cnt_width-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [way_w-1:0]     victim_q, victim_d;
    logic [cnt_width-1:0] hit_count_q, hit_count_d;
    logic [cnt_width-1:0] miss_count_q, miss_count_d;
    logic [cnt_width-1:0] wb_count_q, wb_count_d;

    logic req;
    logic is_write;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    // A simultaneous read+write is serviced as a write.
    assign req      = mem_read | mem_write;
    assign is_write = mem_write;

    // State, victim and counter registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    // Next-state and array/pmem control; strobes are suppressed while reset is held.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = hit_way;
        load_data     = 1'b0;
        data_src      = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        pmem_addr_sel = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        load_lru = 1'b1;
                        hit_inc  = 1'b1;
                        if (is_write) begin
                            load_data  = 1'b1;
                            data_src   = 1'b0;
                            load_dirty = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end else if (req) begin
                        // Point the arrays at the LRU way so the datapath reports its dirtiness.
                        way_sel  = lru_way;
                        victim_d = lru_way;
                        miss_inc = 1'b1;
                        state_d  = victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    way_sel       = victim_q;
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        wb_inc  = 1'b1;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    way_sel   = victim_q;
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data  = 1'b1;
                        data_src   = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters: hold at all-ones instead of wrapping.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (hit_inc && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 1'b1;
        end
        if (miss_inc && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + 1'b1;
        end
        if (wb_inc && (wb_count_q != '1)) begin
            wb_count_d = wb_count_q + 1'b1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_dcache_control.sv
// Purpose: directed, table-driven check of dcache_control hit/miss/writeback sequencing and counters.
// Latency: each vector is one clock; outputs are sampled mid-low-phase, away from the rising edge.
// Backpressure: pmem_resp and CPU request holding are driven explicitly by the vectors.
module tb_dcache_control;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          mem_read, mem_write, mem_resp;
    logic          hit;
    logic [0:0]    hit_way, lru_way, way_sel;
    logic          victim_dirty;
    logic          pmem_read, pmem_write, pmem_resp;
    logic          load_data, data_src, load_tag, load_valid, load_dirty, dirty_in, load_lru;
    logic          pmem_addr_sel;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    int total;
    int bad;

    dcache_control #(.num_ways(2), .cnt_width(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .hit_way(hit_way), .lru_way(lru_way), .victim_dirty(victim_dirty),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .way_sel(way_sel), .load_data(load_data), .data_src(data_src),
        .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty),
        .dirty_in(dirty_in), .load_lru(load_lru), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-output order: {mem_resp, pmem_read, pmem_write, way_sel,
    //  load_data, data_src, load_tag, load_valid, load_dirty, dirty_in, load_lru, pmem_addr_sel}
    typedef struct {
        string      name;
        logic       rd, wr, h, hw, lru, vd, presp;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] outs();
        return {mem_resp, pmem_read, pmem_write, way_sel[0],
                load_data, data_src, load_tag, load_valid,
                load_dirty, dirty_in, load_lru, pmem_addr_sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic h, input logic hw,
                         input logic lru, input logic vd, input logic presp);
        mem_read     = rd;
        mem_write    = wr;
        hit          = h;
        hit_way      = hw;
        lru_way      = lru;
        victim_dirty = vd;
        pmem_resp    = presp;
    endtask

    task automatic addv(input string n, input logic rd, input logic wr, input logic h,
                        input logic hw, input logic lru, input logic vd, input logic presp,
                        input logic [11:0] e);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.h = h; v.hw = hw;
        v.lru = lru; v.vd = vd; v.presp = presp; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        //    name           rd wr h hw lru vd pr  expected
        addv("idle",         0, 0, 0, 0, 0, 0, 0, 12'b0000_0000_0000);
        addv("rd_hit_w1",    1, 0, 1, 1, 0, 0, 0, 12'b1001_0000_0010);
        addv("wr_miss_cln",  0, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000);
        addv("fill_wait1",   0, 1, 0, 0, 1, 0, 0, 12'b0100_0000_0000);
        addv("fill_wait2",   0, 1, 0, 0, 1, 0, 0, 12'b0100_0000_0000);
        addv("fill_wait3",   0, 1, 0, 0, 0, 0, 0, 12'b0100_0000_0000);
        addv("fill_done",    0, 1, 0, 0, 0, 0, 1, 12'b0100_1111_1000);
        addv("wr_merge",     0, 1, 1, 0, 0, 0, 0, 12'b1000_1000_1110);
        addv("rd_miss_dty",  1, 0, 0, 0, 1, 1, 0, 12'b0001_0000_0000);
        addv("wb_wait1",     1, 0, 0, 0, 0, 1, 0, 12'b0011_0000_0001);
        addv("wb_wait2",     1, 0, 0, 0, 1, 0, 0, 12'b0011_0000_0001);
        addv("wb_done",      1, 0, 0, 0, 0, 0, 1, 12'b0011_0000_0001);
        addv("fill2_wait",   1, 0, 0, 0, 0, 0, 0, 12'b0101_0000_0000);
        addv("fill2_done",   1, 0, 0, 0, 0, 0, 1, 12'b0101_1111_1000);
        addv("rd_hit_after", 1, 0, 1, 1, 0, 0, 0, 12'b1001_0000_0010);
        addv("rdwr_hit",     1, 1, 1, 1, 0, 0, 0, 12'b1001_1000_1110);
        addv("idle_presp",   0, 0, 0, 0, 0, 0, 1, 12'b0000_0000_0000);
        addv("idle_end",     0, 0, 0, 0, 0, 0, 0, 12'b0000_0000_0000);

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_outs", {20'd0, outs()}, 32'd0);
        chk("rst_hitc", {28'd0, hit_count}, 32'd0);
        chk("rst_missc", {28'd0, miss_count}, 32'd0);
        chk("rst_wbc", {28'd0, wb_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main vector table, one clock per entry.
        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].h, vecs[i].hw,
                  vecs[i].lru, vecs[i].vd, vecs[i].presp);
            #2;
            chk(vecs[i].name, {20'd0, outs()}, {20'd0, vecs[i].exp});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("cnt_hit", {28'd0, hit_count}, 32'd4);
        chk("cnt_miss", {28'd0, miss_count}, 32'd2);
        chk("cnt_wb", {28'd0, wb_count}, 32'd1);

        // Reset asserted while a fill is outstanding, between clock edges.
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("mid_fill_pr", {31'd0, pmem_read}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drop_pr", {31'd0, pmem_read}, 32'd0);
        chk("rst_drop_ld", {20'd0, outs()}, 32'd0);
        chk("rst_clr_hit", {28'd0, hit_count}, 32'd0);
        chk("rst_clr_miss", {28'd0, miss_count}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("post_rst_idle", {20'd0, outs()}, 32'd0);

        // Saturation: 15 hits reach all-ones, one more must hold it there.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(1, 0, 1, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("hit_at_max", {28'd0, hit_count}, 32'd15);
        @(negedge clk);
        drive(1, 0, 1, 1, 0, 0, 0);
        #2;
        chk("sat_hit_resp", {31'd0, mem_resp}, 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("hit_saturated", {28'd0, hit_count}, 32'd15);
        chk("miss_unmoved", {28'd0, miss_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
